// File: rtl/key_rx_fifo.sv
// Key receive FIFO: buffers SPART key bytes, acknowledges each with clr_rx, and pops to the CPU.
// Define KEY_RX_FIFO_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module key_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        key_data,
  input  logic              key_valid,
  output logic              clr_rx,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              irq,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  logic              clr_rx_reg;
  logic [7:0]        rd_data_reg;
  logic              rd_valid_reg;
  logic              push_ok;
  logic              pop_ok;

  // Flags come only from the registered count, so full/empty seen here are pre-edge values.
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_C);
  assign irq     = ~empty;
  assign push_ok = key_valid & ~full;
  assign pop_ok  = rd_en & ~empty;

  assign count    = count_reg;
  assign clr_rx   = clr_rx_reg;
  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= key_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      clr_rx_reg   <= 1'b0;
      rd_data_reg  <= 8'h00;
      rd_valid_reg <= 1'b0;
    end else begin
      // Every key pulse is acknowledged, even when the byte is dropped on full.
      clr_rx_reg   <= key_valid;
      rd_valid_reg <= pop_ok;
      count_reg    <= count_next;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_data_reg <= mem[rd_ptr_reg];
      end
    end
  end

`ifdef KEY_RX_FIFO_OVF_EN
  logic ovf_reg;

  // A new overflow in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (key_valid && full) begin
      ovf_reg <= 1'b1;
    end else if (ovf_clr) begin
      ovf_reg <= 1'b0;
    end
  end

  assign ovf = ovf_reg;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/key_rx_fifo.md
Name: key_rx_fifo

Overview:
- Downstream consumer of the SPART key-receive wrapper.
- Captures each received key byte on the wrapper's one-cycle key interrupt pulse into a circular FIFO.
- Returns the clear handshake (clr_rx) to the wrapper.
- Presents buffered keys to the processor through a registered pop interface plus a level interrupt request, so keystrokes are not lost while software is busy.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset, asynchronous, active-high.
- key_data  input  8  received key byte from SPART; stable while key_valid is high.
- key_valid  input  1  one-cycle pulse: new key byte available (SPART key_interrupt_pulse).
- clr_rx  output  1  one-cycle acknowledge back to SPART; clears its key interrupt.
- rd_en  input  1  processor pop request, one cycle per byte.
- rd_data  output  8  popped byte, registered.
- rd_valid  output  1  high for exactly one cycle when rd_data carries a newly popped byte.
- empty  output  1  FIFO holds zero entries.
- full  output  1  FIFO holds DEPTH entries.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- irq  output  1  level interrupt to processor; high whenever count != 0.
- ovf  output  1  sticky overflow flag (see Optional Feature).
- ovf_clr  input  1  clears ovf.

Behaviour:
- Reset (async, rst high):
  - Write/read pointers = 0, count = 0, empty = 1, full = 0.
  - clr_rx = 0, rd_data = 8'h00, rd_valid = 0, irq = 0, ovf = 0.
  - Storage contents are don't-care.
- Storage: DEPTH x 8 array; wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH, DEPTH-1 -> 0. Occupancy is tracked with the separate count register, not pointer comparison.
- Push:
  - On a clk edge with key_valid=1 and full=0: mem[wr_ptr] <= key_data, wr_ptr += 1.
  - With key_valid=1 and full=1: the byte is dropped; pointers and contents are unchanged.
- Ack handshake:
  - clr_rx is key_valid registered one cycle: it asserts the cycle after every key_valid, including dropped bytes, and lasts exactly one cycle.
  - Back-to-back key_valid on consecutive cycles produces back-to-back clr_rx.
- Pop:
  - On a clk edge with rd_en=1 and empty=0: rd_data <= mem[rd_ptr], rd_ptr += 1, rd_valid <= 1.
  - Latency is one cycle from rd_en to rd_data/rd_valid.
  - rd_en while empty is ignored: rd_valid <= 0 and rd_data holds its last value.
  - rd_valid is 0 in any cycle without a successful pop.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle (not full, not empty): count unchanged, both pointers advance.
  - Push when full and pop in the same cycle: the push is dropped (full is evaluated pre-edge) and the pop proceeds; count becomes DEPTH-1.
  - Push when empty and pop in the same cycle: the pop is ignored and the push proceeds; count becomes 1. There is no fall-through.
- Flags: empty = (count==0), full = (count==DEPTH), irq = ~empty. All are registered/derived from registered count, with no combinational path from key_valid or rd_en.
- Reset mid-operation: all state returns to reset values immediately and any pending clr_rx is cancelled. The SPART shares rst, so its key interrupt also clears.

Optional Feature:
- Macro KEY_RX_FIFO_OVF_EN.
- Defined:
  - ovf sets to 1 on any clk edge where key_valid=1 and full=1.
  - ovf stays set until an edge with ovf_clr=1 and no new overflow. Set wins over clear in the same cycle.
- Undefined:
  - ovf is tied to 0 and ovf_clr is ignored; no overflow logic is synthesized.
  - Drop behaviour on full is identical in both builds.

Test Plan:
- Reset, then a single push with key_valid pulse and key_data=8'h41 -> clr_rx high on the next cycle only; count=1, empty=0, irq=1. Then rd_en one cycle -> next cycle rd_data=8'h41, rd_valid=1, count=0, irq=0.
- Push 16 bytes 8'h00..8'h0F on consecutive cycles -> full=1, count=16, 16 clr_rx pulses. Pop 16 times -> rd_data sequence 8'h00..8'h0F in order, empty=1, pointers wrapped to 0.
- Fill to 16, push 8'hFF -> count stays 16, clr_rx still pulses, 8'hFF never read back. With KEY_RX_FIFO_OVF_EN, ovf=1 until ovf_clr; without it, ovf=0 throughout.
- With count=5, assert key_valid (8'h55) and rd_en in the same cycle -> count stays 5, the popped byte is the oldest entry, and 8'h55 appears after four more pops.
- rd_en while empty -> rd_valid=0, rd_data unchanged, count stays 0. Simultaneous push (8'h33) and pop while empty -> count=1, rd_valid=0, next pop returns 8'h33.
- Assert rst with count=7 and the cycle after key_valid -> clr_rx=0 immediately, count=0, empty=1, irq=0, ovf=0.
